tx_framer: RTL and testbench

TX_FRAMER -- requirements
Module: tx_framer

---
 rtl/tx_framer.sv | 169 ++++++++++++++++
 tb/tb_tx_framer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_framer.sv
// Serial frame transmitter: start bit, DATA_W payload bits, optional parity, then 1 or 2 stop bits.
// linha, busy and done are registered and computed from the next-state values.
module tx_framer #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned MSB_FIRST    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              send,
    input  logic [DATA_W-1:0] palavra,
    output logic              busy,
    output logic              done,
    output logic              linha
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned IW = $clog2(DATA_W + 1);

    if (DATA_W < 1 || DATA_W > 32 || CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535 ||
        PARITY_EN > 1 || PARITY_ODD > 1 || STOP_BITS < 1 || STOP_BITS > 2 ||
        MSB_FIRST > 1) begin : g_bad_param
        $error("tx_framer: parameter out of legal range");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic              par_q, par_d;
    logic              linha_q, linha_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_clk_c;
    logic [DATA_W-1:0] sh_next_c;

    function automatic logic cur_bit(input logic [DATA_W-1:0] s);
        return (MSB_FIRST != 0) ? s[DATA_W-1] : s[0];
    endfunction

    assign last_clk_c = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
    assign sh_next_c  = (MSB_FIRST != 0) ? (sh_q << 1) : (sh_q >> 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            linha_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            par_q     <= par_d;
            linha_q   <= linha_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state; linha_d is the line level of the cycle that state_d describes.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        idx_d     = idx_q;
        sh_d      = sh_q;
        par_d     = par_q;
        linha_d   = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (send) begin
                    sh_d      = palavra;
                    par_d     = (^palavra) ^ (PARITY_ODD != 0);
                    clk_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = START;
                    linha_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            START: begin
                busy_d  = 1'b1;
                linha_d = 1'b0;
                if (last_clk_c) begin
                    clk_cnt_d = '0;
                    state_d   = DATA;
                    linha_d   = cur_bit(sh_q);
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                busy_d  = 1'b1;
                linha_d = cur_bit(sh_q);
                if (last_clk_c) begin
                    clk_cnt_d = '0;
                    if (idx_q == IW'(DATA_W - 1)) begin
                        idx_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            linha_d = par_q;
                        end else begin
                            state_d = STOP;
                            linha_d = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        sh_d    = sh_next_c;
                        linha_d = cur_bit(sh_next_c);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            PARITY: begin
                busy_d  = 1'b1;
                linha_d = par_q;
                if (last_clk_c) begin
                    clk_cnt_d = '0;
                    state_d   = STOP;
                    linha_d   = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                busy_d = 1'b1;
                // idx_q is reused to count stop bits
                if (last_clk_c) begin
                    clk_cnt_d = '0;
                    if (idx_q == IW'(STOP_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign linha = linha_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_tx_framer.sv
// Directed bench for tx_framer: per-cycle {busy,done,linha} scoreboard over four parameter sets.
module tb_tx_framer;

    logic        clk = 1'b0;
    logic        reset;
    logic        send_a, send_b, send_c, send_d;
    logic [15:0] pal_a;
    logic [7:0]  pal_b, pal_c;
    logic [0:0]  pal_d;
    logic        busy_a, done_a, linha_a;
    logic        busy_b, done_b, linha_b;
    logic        busy_c, done_c, linha_c;
    logic        busy_d, done_d, linha_d;

    int          sel;
    int          n_total = 0;
    int          n_fail  = 0;
    logic [2:0]  q[$];

    always #5 clk = ~clk;

    tx_framer u_a (
        .clock(clk), .reset(reset), .send(send_a), .palavra(pal_a),
        .busy(busy_a), .done(done_a), .linha(linha_a)
    );

    tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0),
                .STOP_BITS(1), .MSB_FIRST(0)) u_b (
        .clock(clk), .reset(reset), .send(send_b), .palavra(pal_b),
        .busy(busy_b), .done(done_b), .linha(linha_b)
    );

    tx_framer #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1),
                .STOP_BITS(2), .MSB_FIRST(0)) u_c (
        .clock(clk), .reset(reset), .send(send_c), .palavra(pal_c),
        .busy(busy_c), .done(done_c), .linha(linha_c)
    );

    tx_framer #(.DATA_W(1), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1),
                .STOP_BITS(2), .MSB_FIRST(1)) u_d (
        .clock(clk), .reset(reset), .send(send_d), .palavra(pal_d),
        .busy(busy_d), .done(done_d), .linha(linha_d)
    );

    // Expected per-cycle {busy,done,linha} for one frame, ending with the done cycle.
    function automatic void push_frame(int dw, int cpb, int pen, int podd, int stop,
                                       int msb, logic [31:0] w);
        logic par;
        logic b;
        par = (podd != 0);
        for (int i = 0; i < dw; i++) par = par ^ w[i];
        repeat (cpb) q.push_back(3'b100);
        for (int i = 0; i < dw; i++) begin
            b = (msb != 0) ? w[dw-1-i] : w[i];
            repeat (cpb) q.push_back({2'b10, b});
        end
        if (pen != 0) repeat (cpb) q.push_back({2'b10, par});
        repeat (stop * cpb) q.push_back(3'b101);
        q.push_back(3'b011);
    endfunction

    function automatic void push_sel(logic [31:0] w);
        case (sel)
            0:       push_frame(16, 1, 0, 0, 1, 1, w);
            1:       push_frame(8, 4, 1, 0, 1, 0, w);
            2:       push_frame(8, 4, 1, 1, 2, 0, w);
            default: push_frame(1, 3, 1, 1, 2, 1, w);
        endcase
    endfunction

    task automatic step(input string tag);
        logic [2:0] obs;
        logic [2:0] exp;
        @(posedge clk);
        #1;
        case (sel)
            0:       obs = {busy_a, done_a, linha_a};
            1:       obs = {busy_b, done_b, linha_b};
            2:       obs = {busy_c, done_c, linha_c};
            default: obs = {busy_d, done_d, linha_d};
        endcase
        exp = (q.size() > 0) ? q.pop_front() : 3'b001;
        n_total++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: busy/done/linha observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 400) begin
            step(tag);
            guard++;
        end
        if (q.size() > 0) begin
            n_total++;
            n_fail++;
            $error("FAIL %s: queue not drained, left=%0d expected=0", tag, q.size());
            q.delete();
        end
    endtask

    initial begin
        sel    = 0;
        reset  = 1'b1;
        send_a = 1'b1; send_b = 1'b0; send_c = 1'b0; send_d = 1'b0;
        pal_a  = 16'hA5C3; pal_b = '0; pal_c = '0; pal_d = '0;
        step("reset_over_send");
        step("reset_hold");
        reset  = 1'b0;
        send_a = 1'b0;
        step("idle_after_reset");

        // Default config, A5C3; palavra changed after capture must not matter
        send_a = 1'b1;
        pal_a  = 16'hA5C3;
        push_sel(32'(pal_a));
        step("a5c3_start");
        send_a = 1'b0;
        pal_a  = 16'hFFFF;
        drain("a5c3_frame");
        step("a5c3_idle");

        // send held across two frames, palavra changed mid-frame
        send_a = 1'b1;
        pal_a  = 16'h1234;
        push_sel(32'(pal_a));
        repeat (5) step("b2b_first");
        pal_a = 16'h8001;
        drain("b2b_first");
        push_sel(32'(pal_a));
        step("b2b_second_start");
        send_a = 1'b0;
        drain("b2b_second");
        step("b2b_idle");

        // send pulsed while busy
        send_a = 1'b1;
        pal_a  = 16'h5A5A;
        push_sel(32'(pal_a));
        step("busy_send_start");
        send_a = 1'b0;
        repeat (4) step("busy_send_pre");
        send_a = 1'b1;
        pal_a  = 16'hFFFF;
        step("busy_send_pulse");
        send_a = 1'b0;
        drain("busy_send_frame");
        step("busy_send_idle");

        // reset in the 5th data bit, then immediate restart
        send_a = 1'b1;
        pal_a  = 16'hC3A5;
        push_sel(32'(pal_a));
        step("abort_start");
        send_a = 1'b0;
        repeat (5) step("abort_bits");
        reset = 1'b1;
        q.delete();
        step("abort_reset");
        reset  = 1'b0;
        send_a = 1'b1;
        pal_a  = 16'h7E81;
        push_sel(32'(pal_a));
        step("restart_start");
        send_a = 1'b0;
        drain("restart_frame");
        step("restart_idle");

        // 8 bits, 4 clk/bit, even parity, LSB first
        sel    = 1;
        send_b = 1'b1;
        pal_b  = 8'hA5;
        push_sel(32'(pal_b));
        step("even_par_start");
        send_b = 1'b0;
        drain("even_par_frame");
        step("even_par_idle");

        // odd parity, 2 stop bits, all-zero payload
        sel    = 2;
        send_c = 1'b1;
        pal_c  = 8'h00;
        push_sel(32'(pal_c));
        step("odd_par_start");
        send_c = 1'b0;
        drain("odd_par_frame");
        step("odd_par_idle");

        // single-bit payload, back-to-back
        sel    = 3;
        send_d = 1'b1;
        pal_d  = 1'b1;
        push_sel(32'(pal_d));
        step("w1_first_start");
        pal_d = 1'b0;
        drain("w1_first");
        push_sel(32'(pal_d));
        step("w1_second_start");
        send_d = 1'b0;
        drain("w1_second");
        step("w1_idle");

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
